// File: rtl/branch_predictor.sv
// branch_predictor
// Purpose: fetch-stage branch predictor. There is one table of 2-bit saturating
// counters, indexed by pc[IW+1:2]. A lookup is registered with one cycle of
// latency. A resolved-branch update that targets the same index as the lookup
// is bypassed into that lookup (write-first).
// Optional target buffer: define BRANCH_PREDICTOR_BTB_EN to add a valid bit,
// a tag and a target to every entry.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   lookup_valid_i fetch lookup request
//   lookup_pc_i    fetch PC
//   stall_i        hold all prediction outputs
//   flush_i        invalidate the registered prediction (wins over stall_i)
//   upd_valid_i    resolved-branch update strobe
//   upd_pc_i       PC of the resolved branch
//   upd_taken_i    actual outcome
//   upd_target_i   actual target
//   pred_valid_o   registered prediction is valid
//   pred_taken_o   predicted taken
//   pred_hit_o     target-buffer hit (0 without the target buffer)
//   pred_target_o  predicted target (0 without the target buffer)
module branch_predictor #(
    parameter int         ENTRIES  = 64,
    parameter int         ADDR_W   = 32,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lookup_valid_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic              pred_hit_o,
    output logic [ADDR_W-1:0] pred_target_o
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = ADDR_W - IW - 2;

    logic [1:0]    ctr [ENTRIES];
    logic [IW-1:0] lk_idx;
    logic [IW-1:0] up_idx;
    logic [1:0]    up_ctr_next;
    logic [1:0]    lk_ctr;
    logic          bypass;

    logic              hit_c;
    logic              taken_c;
    logic [ADDR_W-1:0] target_c;

    assign lk_idx = lookup_pc_i[IW+1:2];
    assign up_idx = upd_pc_i[IW+1:2];
    assign bypass = upd_valid_i && (up_idx == lk_idx);

    always_comb begin
        up_ctr_next = ctr[up_idx];
        if (upd_taken_i && ctr[up_idx] != 2'd3) begin
            up_ctr_next = ctr[up_idx] + 2'd1;
        end else if (!upd_taken_i && ctr[up_idx] != 2'd0) begin
            up_ctr_next = ctr[up_idx] - 2'd1;
        end
    end

    // Write-first: a same-index update is visible to the lookup in this cycle.
    assign lk_ctr = bypass ? up_ctr_next : ctr[lk_idx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (upd_valid_i) begin
            ctr[up_idx] <= up_ctr_next;
        end
    end

`ifdef BRANCH_PREDICTOR_BTB_EN
    logic              btb_v   [ENTRIES];
    logic [TW-1:0]     btb_tag [ENTRIES];
    logic [ADDR_W-1:0] btb_tgt [ENTRIES];
    logic              bypass_w;
    logic              lk_v;
    logic [TW-1:0]     lk_tag;
    logic              unused_pc_bits;

    // A not-taken update leaves the entry alone, so it is only bypassed when taken.
    assign bypass_w = bypass && upd_taken_i;
    assign lk_v     = bypass_w ? 1'b1 : btb_v[lk_idx];
    assign lk_tag   = bypass_w ? upd_pc_i[ADDR_W-1:IW+2] : btb_tag[lk_idx];
    assign target_c = bypass_w ? upd_target_i : btb_tgt[lk_idx];
    assign hit_c    = lk_v && (lk_tag == lookup_pc_i[ADDR_W-1:IW+2]);
    assign taken_c  = hit_c && lk_ctr[1];
    assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_v[i]   <= 1'b0;
                btb_tag[i] <= '0;
                btb_tgt[i] <= '0;
            end
        end else if (upd_valid_i && upd_taken_i) begin
            btb_v[up_idx]   <= 1'b1;
            btb_tag[up_idx] <= upd_pc_i[ADDR_W-1:IW+2];
            btb_tgt[up_idx] <= upd_target_i;
        end
    end
`else
    logic unused_pc_bits;

    // Direction only: decode computes the target.
    assign hit_c    = 1'b0;
    assign taken_c  = lk_ctr[1];
    assign target_c = '0;
    assign unused_pc_bits = ^{lookup_pc_i[ADDR_W-1:IW+2], lookup_pc_i[1:0],
                              upd_pc_i[ADDR_W-1:IW+2], upd_pc_i[1:0], upd_target_i};
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pred_valid_o  <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_hit_o    <= 1'b0;
            pred_target_o <= '0;
        end else if (flush_i) begin
            pred_valid_o  <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_hit_o    <= 1'b0;
            pred_target_o <= '0;
        end else if (!stall_i) begin
            if (lookup_valid_i) begin
                pred_valid_o  <= 1'b1;
                pred_taken_o  <= taken_c;
                pred_hit_o    <= hit_c;
                pred_target_o <= target_c;
            end else begin
                pred_valid_o  <= 1'b0;
                pred_taken_o  <= 1'b0;
                pred_hit_o    <= 1'b0;
                pred_target_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
// Purpose: scoreboard bench for branch_predictor with the default parameters
// (ENTRIES=64, ADDR_W=32). A reference table of counters (and of target-buffer
// entries when BRANCH_PREDICTOR_BTB_EN is defined) works out the expected
// prediction each time a cycle is driven. The bench queues that expectation and
// compares it with the DUT outputs one cycle later.
module tb_branch_predictor;
    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        stall;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        pred_valid;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;

    branch_predictor dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .lookup_valid_i (lookup_valid),
        .lookup_pc_i    (lookup_pc),
        .stall_i        (stall),
        .flush_i        (flush),
        .upd_valid_i    (upd_valid),
        .upd_pc_i       (upd_pc),
        .upd_taken_i    (upd_taken),
        .upd_target_i   (upd_target),
        .pred_valid_o   (pred_valid),
        .pred_taken_o   (pred_taken),
        .pred_hit_o     (pred_hit),
        .pred_target_o  (pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        t;
        logic        h;
        logic [31:0] tg;
        bit          full;   // hit/target are defined for this prediction
    } exp_t;

    exp_t        sb_q[$];
    exp_t        prev;
    logic [1:0]  m_ctr [64];
    logic        m_bv  [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr[i] = 2'b01;
            m_bv[i]  = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        prev = '{default: 0};
    endtask

    task automatic cycle(input string tag, input bit lv, input logic [31:0] lpc,
                         input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utg, input bit st, input bit fl);
        exp_t e;
        exp_t got;
        int   li;
        int   ui;
        @(negedge clk);
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_taken    = ut;
        upd_target   = utg;
        stall        = st;
        flush        = fl;
        li = int'(lpc[7:2]);
        ui = int'(upc[7:2]);
        if (uv) begin
            if (ut && m_ctr[ui] != 2'd3) m_ctr[ui] = m_ctr[ui] + 2'd1;
            else if (!ut && m_ctr[ui] != 2'd0) m_ctr[ui] = m_ctr[ui] - 2'd1;
            if (ut) begin
                m_bv[ui]  = 1'b1;
                m_tag[ui] = upc[31:8];
                m_tgt[ui] = utg;
            end
        end
        e = '{default: 0};
        if (fl) begin
            e = '{default: 0};
        end else if (st) begin
            e = prev;
        end else if (lv) begin
            e.v    = 1'b1;
            e.full = 1'b1;
`ifdef BRANCH_PREDICTOR_BTB_EN
            e.h  = m_bv[li] && (m_tag[li] == lpc[31:8]);
            e.t  = e.h && m_ctr[li][1];
            e.tg = m_tgt[li];
`else
            e.h  = 1'b0;
            e.t  = m_ctr[li][1];
            e.tg = '0;
`endif
        end
        prev = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_val({tag, ".valid"}, {31'd0, pred_valid}, {31'd0, got.v});
            check_val({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, got.t});
            if (got.full) begin
                check_val({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, got.h});
                check_val({tag, ".target"}, pred_target, got.tg);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, ".valid"}, {31'd0, pred_valid}, 32'd0);
        check_val({tag, ".taken"}, {31'd0, pred_taken}, 32'd0);
        check_val({tag, ".hit"}, {31'd0, pred_hit}, 32'd0);
        check_val({tag, ".target"}, pred_target, 32'd0);
    endtask

    initial begin
        logic [31:0] pcs [6];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        pcs[3] = 32'h200; pcs[4] = 32'h204; pcs[5] = 32'h10C;

        rst_n = 1'b0;
        lookup_valid = 1'b0; lookup_pc = '0;
        stall = 1'b0; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset: lookup of an untrained PC, weakly not-taken.
        cycle("rst_val", 1, 32'h100, 0, 0, 0, 0, 0, 0);

        // Saturation at 0x104.
        cycle("sat_u1", 0, 0, 1, 32'h104, 1, 32'h500, 0, 0);
        cycle("sat_u2", 0, 0, 1, 32'h104, 1, 32'h500, 0, 0);
        cycle("sat_l1", 1, 32'h104, 0, 0, 0, 0, 0, 0);
        cycle("sat_u3", 0, 0, 1, 32'h104, 1, 32'h500, 0, 0);
        cycle("sat_u4", 0, 0, 1, 32'h104, 0, 0, 0, 0);
        cycle("sat_l2", 1, 32'h104, 0, 0, 0, 0, 0, 0);
        cycle("sat_u5", 0, 0, 1, 32'h104, 0, 0, 0, 0);
        cycle("sat_l3", 1, 32'h104, 0, 0, 0, 0, 0, 0);

        // Saturation at 0 for 0x10C, then one taken step back up to 1.
        cycle("sat0_u1", 0, 0, 1, 32'h10C, 0, 0, 0, 0);
        cycle("sat0_u2", 0, 0, 1, 32'h10C, 0, 0, 0, 0);
        cycle("sat0_u3", 0, 0, 1, 32'h10C, 1, 32'h600, 0, 0);
        cycle("sat0_l", 1, 32'h10C, 0, 0, 0, 0, 0, 0);

        // Write-first bypass at 0x108.
        cycle("bypass", 1, 32'h108, 1, 32'h108, 1, 32'h700, 0, 0);

        // Different indices in the same cycle, aliasing and ignored low bits.
        cycle("diff_idx", 1, 32'h104, 1, 32'h108, 1, 32'h700, 0, 0);
        cycle("alias", 1, 32'h20C, 0, 0, 0, 0, 0, 0);
        cycle("lowbits", 1, 32'h10B, 0, 0, 0, 0, 0, 0);

        // Tag alias: 0x100 and 0x200 share index 0.
        cycle("tag_u1", 0, 0, 1, 32'h100, 1, 32'h400, 0, 0);
        cycle("tag_u2", 0, 0, 1, 32'h100, 1, 32'h400, 0, 0);
        cycle("tag_l1", 1, 32'h100, 0, 0, 0, 0, 0, 0);
        cycle("tag_l2", 1, 32'h200, 0, 0, 0, 0, 0, 0);

        // Stall holds outputs while the lookup PC changes; flush wins over stall.
        cycle("stall_l", 1, 32'h100, 0, 0, 0, 0, 0, 0);
        cycle("stall1", 1, 32'h104, 0, 0, 0, 0, 1, 0);
        cycle("stall2", 1, 32'h200, 0, 0, 0, 0, 1, 0);
        cycle("stall3", 0, 32'h108, 0, 0, 0, 0, 1, 0);
        cycle("flush_st", 1, 32'h100, 0, 0, 0, 0, 1, 1);
        cycle("idle", 0, 32'h100, 0, 0, 0, 0, 0, 0);

        // Mixed random traffic.
        for (int k = 0; k < 60; k++) begin
            cycle("rand", $urandom_range(1, 0) != 0, pcs[$urandom_range(5, 0)],
                  $urandom_range(1, 0) != 0, pcs[$urandom_range(5, 0)],
                  $urandom_range(1, 0) != 0, 32'h1000 + 32'($urandom_range(255, 0)) * 4,
                  $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0);
        end

        // Asynchronous reset between edges, with an update and a lookup in flight.
        cycle("pre_rst_u", 0, 0, 1, 32'h104, 1, 32'h500, 0, 0);
        cycle("pre_rst_u2", 0, 0, 1, 32'h104, 1, 32'h500, 0, 0);
        cycle("pre_rst_l", 1, 32'h104, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        lookup_valid = 1'b1; lookup_pc = 32'h104;
        upd_valid = 1'b1; upd_pc = 32'h104; upd_taken = 1'b1; upd_target = 32'h500;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(posedge clk);
        #1;
        check_outputs_zero("rst_hold");
        @(negedge clk);
        lookup_valid = 1'b0; upd_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle("post_rst", 1, 32'h104, 0, 0, 0, 0, 0, 0);
        cycle("post_rst2", 1, 32'h100, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
